// File: rtl/mem_inorder_iq_pkg.sv
// Shared types for the in-order memory issue queue: the write, wake and read
// port structs, the stored payload layout and a small popcount helper.
package mem_inorder_iq_pkg;

   localparam int FETCH_WIDTH  = 4;
   localparam int WAKE_NUM     = 2;
   localparam int COMMIT_WIDTH = 2;
   localparam int AREG_W       = 5;
   localparam int PREG_W       = 6;
   localparam int CTL_W        = 8;
   localparam int XLEN         = 32;
   localparam int MIQ_QLEN     = 8;

   // Pointer for the default depth: index bits plus one wrap bit.
   typedef logic [$clog2(MIQ_QLEN):0] miq_ptr_t;

   typedef struct packed {
      logic [AREG_W-1:0] id;
      logic [PREG_W-1:0] pid;
      logic              valid;
      logic              forward_en;
   } src_op_t;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] dst;
      logic [CTL_W-1:0]  ctl;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      src_op_t           src1;
      src_op_t           src2;
   } write_req_t;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] id;
   } wake_req_t;

   // Full view of one queued uop as presented on the issue ports.
   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] dst;
      logic [CTL_W-1:0]  ctl;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      src_op_t           src1;
      src_op_t           src2;
   } miq_entry_t;

   // Static part of an entry kept in the banked payload RAM.
   typedef struct packed {
      logic [PREG_W-1:0] dst;
      logic [CTL_W-1:0]  ctl;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [AREG_W-1:0] src1Id;
      logic [AREG_W-1:0] src2Id;
   } miq_payload_t;

   typedef struct packed {
      miq_entry_t entry;
   } read_resp_t;

   // Number of set bits in a write-group valid mask.
   function automatic logic [$clog2(FETCH_WIDTH):0] popcount_wvalid(input logic [FETCH_WIDTH-1:0] mask);
      logic [$clog2(FETCH_WIDTH):0] cnt;
      cnt = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         cnt = cnt + {{$clog2(FETCH_WIDTH){1'b0}}, mask[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/mem_inorder_iq_compactor.sv
// Maps a sparse write-group valid mask onto payload banks: the n-th valid slot
// lands in bank (base + n) mod WNUM, so each bank receives at most one write.
module miq_compactor
   import mem_inorder_iq_pkg::*;
#(
   parameter int WNUM = 4
) (
   input  logic [WNUM-1:0]                      i_mask,
   input  logic [$clog2(WNUM)-1:0]              i_base,
   output logic [WNUM-1:0]                      o_bankEn,
   output logic [WNUM-1:0][$clog2(WNUM)-1:0]    o_bankSel,
   output logic [$clog2(WNUM):0]                o_cnt
);

   localparam int SEL_W = $clog2(WNUM);

   logic [SEL_W-1:0] w_rank;
   logic [SEL_W-1:0] w_bank;

   // Walk the slots in program order, giving each valid one the next bank.
   always_comb begin
      o_bankEn  = '0;
      o_bankSel = '0;
      w_rank    = '0;
      w_bank    = '0;
      for (int i = 0; i < WNUM; i++) begin
         if (i_mask[i]) begin
            w_bank            = i_base + w_rank;
            o_bankEn[w_bank]  = 1'b1;
            o_bankSel[w_bank] = SEL_W'(i);
            w_rank            = w_rank + SEL_W'(1);
         end
      end
   end

   assign o_cnt = popcount_wvalid(i_mask);

endmodule

// File: rtl/mem_inorder_iq.sv
// In-order issue queue for the memory pipe. Circular buffer with wrap-bit
// pointers; accepts a compacted write group, tracks operand readiness from
// wake/retire broadcasts and issues the oldest run of ready uops.
module mem_inorder_iq
   import mem_inorder_iq_pkg::*;
#(
   parameter int QLEN = 8,
   parameter int WNUM = 4,
   parameter int RNUM = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_flush,
   input  logic                             i_wen,
   input  write_req_t [WNUM-1:0]            i_write,
   input  logic                             i_stall,
   input  wake_req_t  [WAKE_NUM-1:0]        i_wake,
   input  wake_req_t  [COMMIT_WIDTH-1:0]    i_retire,
   output read_resp_t [RNUM-1:0]            o_read,
   output logic [$clog2(QLEN):0]            o_free_cnt,
   output logic                             o_full
);

   localparam int IDX_W = $clog2(QLEN);
   localparam int PTR_W = IDX_W + 1;
   localparam int SEL_W = $clog2(WNUM);
   localparam int NW_W  = SEL_W + 1;
   localparam int K_W   = $clog2(RNUM) + 1;

   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [PTR_W-1:0]  r_freeCnt;
   logic [QLEN-1:0]   r_valid;
   logic [QLEN-1:0]   r_v1;
   logic [QLEN-1:0]   r_v2;
   logic [QLEN-1:0]   r_f1;
   logic [QLEN-1:0]   r_f2;
   logic [PREG_W-1:0] r_p1 [QLEN];
   logic [PREG_W-1:0] r_p2 [QLEN];
   miq_payload_t      r_pay [QLEN];

   logic                        w_full;
   logic                        w_accept;
   logic [WNUM-1:0]             w_mask;
   logic [WNUM-1:0]             w_bankEn;
   logic [WNUM-1:0][SEL_W-1:0]  w_bankSel;
   logic [NW_W-1:0]             w_nw;
   logic [NW_W-1:0]             w_nwAcc;
   logic [IDX_W-1:0]            w_bankIdx [WNUM];
   logic [PREG_W-1:0]           w_wrP1 [WNUM];
   logic [PREG_W-1:0]           w_wrP2 [WNUM];
   logic [WNUM-1:0]             w_wrV1;
   logic [WNUM-1:0]             w_wrV2;
   logic [WNUM-1:0]             w_wrF1;
   logic [WNUM-1:0]             w_wrF2;
   miq_payload_t                w_wrPay [WNUM];
   logic [IDX_W-1:0]            w_rdIdx [RNUM];
   logic [RNUM-1:0]             w_rdy;
   logic                        w_run;
   logic [K_W-1:0]              w_k;

   function automatic logic wakeHit(input logic [PREG_W-1:0] pid, input wake_req_t [WAKE_NUM-1:0] req);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < WAKE_NUM; j++) begin
         if (req[j].valid && (req[j].id == pid)) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic retireHit(input logic [PREG_W-1:0] pid, input wake_req_t [COMMIT_WIDTH-1:0] req);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         if (req[j].valid && (req[j].id == pid)) hit = 1'b1;
      end
      return hit;
   endfunction

   assign w_full     = (r_freeCnt < PTR_W'(WNUM));
   assign o_full     = w_full;
   assign o_free_cnt = r_freeCnt;
   assign w_accept   = i_wen && !w_full;
   assign w_nwAcc    = w_accept ? w_nw : '0;

   for (genvar i = 0; i < WNUM; i++) begin : g_mask
      assign w_mask[i] = i_write[i].valid;
   end

   miq_compactor #(.WNUM(WNUM)) u_compactor (
      .i_mask    (w_mask),
      .i_base    (r_tail[SEL_W-1:0]),
      .o_bankEn  (w_bankEn),
      .o_bankSel (w_bankSel),
      .o_cnt     (w_nw)
   );

   // Each bank's target row is the free slot at tail + (bank - tail) mod WNUM;
   // the selected uop's operands are pre-matched against this cycle's broadcasts.
   for (genvar b = 0; b < WNUM; b++) begin : g_bank
      logic [SEL_W-1:0] w_off;
      assign w_off        = SEL_W'(b) - r_tail[SEL_W-1:0];
      assign w_bankIdx[b] = r_tail[IDX_W-1:0] + IDX_W'(w_off);
      assign w_wrP1[b]    = i_write[w_bankSel[b]].src1.pid;
      assign w_wrP2[b]    = i_write[w_bankSel[b]].src2.pid;
      assign w_wrV1[b]    = i_write[w_bankSel[b]].src1.valid | wakeHit(w_wrP1[b], i_wake) | retireHit(w_wrP1[b], i_retire);
      assign w_wrV2[b]    = i_write[w_bankSel[b]].src2.valid | wakeHit(w_wrP2[b], i_wake) | retireHit(w_wrP2[b], i_retire);
      assign w_wrF1[b]    = i_write[w_bankSel[b]].src1.forward_en & ~retireHit(w_wrP1[b], i_retire);
      assign w_wrF2[b]    = i_write[w_bankSel[b]].src2.forward_en & ~retireHit(w_wrP2[b], i_retire);
      assign w_wrPay[b]   = '{dst:    i_write[w_bankSel[b]].dst,
                              ctl:    i_write[w_bankSel[b]].ctl,
                              imm:    i_write[w_bankSel[b]].imm,
                              pc:     i_write[w_bankSel[b]].pc,
                              src1Id: i_write[w_bankSel[b]].src1.id,
                              src2Id: i_write[w_bankSel[b]].src2.id};
   end

   for (genvar i = 0; i < RNUM; i++) begin : g_rdIdx
      assign w_rdIdx[i] = r_head[IDX_W-1:0] + IDX_W'(i);
      assign w_rdy[i]   = r_valid[w_rdIdx[i]] & r_v1[w_rdIdx[i]] & r_v2[w_rdIdx[i]];
   end

   // Issue count: length of the ready run starting at head, so a stalled head blocks everyone.
   always_comb begin
      w_k   = '0;
      w_run = 1'b1;
      for (int i = 0; i < RNUM; i++) begin
         w_run = w_run & w_rdy[i];
         if (w_run) w_k = w_k + K_W'(1);
      end
      if (i_stall || i_flush) w_k = '0;
   end

   // Drive the issue window from head onward; only the first k slots are marked valid.
   always_comb begin
      o_read = '0;
      for (int i = 0; i < RNUM; i++) begin
         o_read[i].entry.valid           = (K_W'(i) < w_k);
         o_read[i].entry.dst             = r_pay[w_rdIdx[i]].dst;
         o_read[i].entry.ctl             = r_pay[w_rdIdx[i]].ctl;
         o_read[i].entry.imm             = r_pay[w_rdIdx[i]].imm;
         o_read[i].entry.pc              = r_pay[w_rdIdx[i]].pc;
         o_read[i].entry.src1.id         = r_pay[w_rdIdx[i]].src1Id;
         o_read[i].entry.src1.pid        = r_p1[w_rdIdx[i]];
         o_read[i].entry.src1.valid      = r_v1[w_rdIdx[i]];
         o_read[i].entry.src1.forward_en = r_f1[w_rdIdx[i]];
         o_read[i].entry.src2.id         = r_pay[w_rdIdx[i]].src2Id;
         o_read[i].entry.src2.pid        = r_p2[w_rdIdx[i]];
         o_read[i].entry.src2.valid      = r_v2[w_rdIdx[i]];
         o_read[i].entry.src2.forward_en = r_f2[w_rdIdx[i]];
      end
   end

   // Pointer, free-count and valid-bit bookkeeping; flush clears everything like reset.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_valid   <= '0;
         r_freeCnt <= PTR_W'(QLEN);
      end else begin
         for (int i = 0; i < RNUM; i++) begin
            if (K_W'(i) < w_k) r_valid[w_rdIdx[i]] <= 1'b0;
         end
         for (int b = 0; b < WNUM; b++) begin
            if (w_accept && w_bankEn[b]) r_valid[w_bankIdx[b]] <= 1'b1;
         end
         r_head    <= r_head + PTR_W'(w_k);
         r_tail    <= r_tail + PTR_W'(w_nwAcc);
         r_freeCnt <= r_freeCnt + PTR_W'(w_k) - PTR_W'(w_nwAcc);
      end
   end

   // Operand readiness and payload: broadcasts update resident entries, then new writes overwrite their rows.
   always_ff @(posedge clk) begin
      for (int q = 0; q < QLEN; q++) begin
         if (wakeHit(r_p1[q], i_wake)) r_v1[q] <= 1'b1;
         if (wakeHit(r_p2[q], i_wake)) r_v2[q] <= 1'b1;
         if (retireHit(r_p1[q], i_retire)) begin
            r_v1[q] <= 1'b1;
            r_f1[q] <= 1'b0;
         end
         if (retireHit(r_p2[q], i_retire)) begin
            r_v2[q] <= 1'b1;
            r_f2[q] <= 1'b0;
         end
      end
      for (int b = 0; b < WNUM; b++) begin
         if (w_accept && w_bankEn[b]) begin
            r_p1[w_bankIdx[b]]  <= w_wrP1[b];
            r_p2[w_bankIdx[b]]  <= w_wrP2[b];
            r_v1[w_bankIdx[b]]  <= w_wrV1[b];
            r_v2[w_bankIdx[b]]  <= w_wrV2[b];
            r_f1[w_bankIdx[b]]  <= w_wrF1[b];
            r_f2[w_bankIdx[b]]  <= w_wrF2[b];
            r_pay[w_bankIdx[b]] <= w_wrPay[b];
         end
      end
   end

   // A write group presented while full is dropped; upstream should have held it.
   a_noWriteWhenFull: assert property (@(posedge clk) disable iff (reset || i_flush) !(i_wen && w_full))
      else $warning("[mem_inorder_iq] write group dropped while queue full");

endmodule
